// File: rtl/add16_seq_arbiter_if.sv
// Bundle of request/operand/result signals shared by two requesters and
// the time-shared slice adder. The DUT sits on the slave side.
//
// Handshake: reqN is a level request; it is sampled only while the arbiter
// is idle. Once granted, operands and carry-in are latched and reqN may
// drop freely. ackN pulses for exactly one cycle together with done, at
// which point sum/cout hold the finished result until the next done.
interface add16_seq_arbiter_if #(
    parameter int WIDTH = 16
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             cin0;
    logic             cin1;
    logic             ack0;
    logic             ack1;
    logic             gnt_id;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output req0, req1, a0, b0, a1, b1, cin0, cin1,
        input  ack0, ack1, gnt_id, busy, done, sum, cout
    );

    modport slave (
        input  req0, req1, a0, b0, a1, b1, cin0, cin1,
        output ack0, ack1, gnt_id, busy, done, sum, cout
    );
endinterface

// File: rtl/add16_seq_arbiter.sv
// Two-requester round-robin arbiter in front of a WIDTH-bit adder built
// from a single 4-bit ripple slice reused over N = WIDTH/4 cycles.
// sum/cout only change when the last slice completes, so the visible
// result is never half-updated.
module add16_seq_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    add16_seq_arbiter_if.slave   bus,
    output logic [1:0]           dbg_state
);
    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] sum_q;
    logic [KW-1:0]    k_q;
    logic             carry_q;
    logic             cout_q;
    logic             gnt_q;
    logic             last_q;
    logic             any_req;
    logic             grant_d;
    logic [3:0]       sx;
    logic [3:0]       sy;
    logic [3:0]       ss;
    logic             sc;
    logic             rc;

    assign any_req = bus.req0 | bus.req1;

    // Pick a winner: a lone request wins, contention goes to whoever did not win last.
    always_comb begin
        grant_d = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
    end

    // 4-bit ripple slice operating on nibble k of the latched operands.
    always_comb begin
        sx = a_q[{k_q, 2'b00} +: 4];
        sy = b_q[{k_q, 2'b00} +: 4];
        ss = 4'h0;
        rc = carry_q;
        for (int i = 0; i < 4; i++) begin
            ss[i] = sx[i] ^ sy[i] ^ rc;
            rc    = (sx[i] & sy[i]) | (rc & (sx[i] ^ sy[i]));
        end
        sc = rc;
    end

    // Result register with the current slice merged in.
    always_comb begin
        res_d = res_q;
        res_d[{k_q, 2'b00} +: 4] = ss;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ADD;
            ADD:     if (k_q == K_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Grant capture, slice stepping and result publication.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        gnt_q   <= grant_d;
                        last_q  <= grant_d;
                        a_q     <= grant_d ? bus.a1 : bus.a0;
                        b_q     <= grant_d ? bus.b1 : bus.b0;
                        carry_q <= grant_d ? bus.cin1 : bus.cin0;
                        k_q     <= '0;
                    end
                end
                ADD: begin
                    res_q   <= res_d;
                    carry_q <= sc;
                    k_q     <= k_q + KW'(1);
                    if (k_q == K_LAST) begin
                        sum_q  <= res_d;
                        cout_q <= sc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.done   = (state_q == DONE);
    assign bus.busy   = (state_q != IDLE);
    assign bus.ack0   = (state_q == DONE) & ~gnt_q;
    assign bus.ack1   = (state_q == DONE) &  gnt_q;
    assign bus.gnt_id = gnt_q;
    assign bus.sum    = sum_q;
    assign bus.cout   = cout_q;
    assign dbg_state  = state_q;
endmodule

// File: doc/add16_seq_arbiter.md
ADD16_SEQ_ARBITER -- requirements
Module: add16_seq_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be a multiple of 4 and at least 4; N = WIDTH/4 slices.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 req0, req1  in  1 each  level request from requester 0 / 1.
REQ-005 a0, b0  in  WIDTH each  operands, requester 0.
REQ-006 a1, b1  in  WIDTH each  operands, requester 1.
REQ-007 cin0, cin1  in  1 each  carry-in, requester 0 / 1.
REQ-008 ack0, ack1  out  1 each  one-cycle completion pulse to requester 0 / 1.
REQ-009 gnt_id  out  1  index of the requester owning the current or last operation.
REQ-010 busy  out  1  high while an operation is in progress (ADD or DONE).
REQ-011 done  out  1  one-cycle pulse; sum/cout valid.
REQ-012 sum  out  WIDTH  result of the last completed operation.
REQ-013 cout  out  1  carry-out of the last completed operation.

Function
REQ-014 Datapath: one 4-bit combinational ripple-adder slice (X, Y, Cin -> S, Cout), time-shared over N cycles; no WIDTH-bit adder instantiated.
REQ-015 FSM states: IDLE, ADD, DONE.
REQ-016 IDLE: at an edge with req0 or req1 high -> grant one requester, capture its a, b, cin into internal registers, set slice index k=0, carry=cin, go to ADD; otherwise remain in IDLE.
REQ-017 Arbitration: single request wins; if both are high, grant the requester not granted last (round-robin); last-grant pointer resets to 1, so requester 0 wins the first contention.
REQ-018 ADD: each edge, slice k adds a[4k+3:4k] + b[4k+3:4k] + carry; writes S to the result register bits [4k+3:4k]; carry <= Cout; k <= k+1; after slice N-1, go to DONE.
REQ-019 DONE: done=1 and ack of gnt_id=1 for exactly this one cycle; sum = full result; cout = final carry; next edge -> IDLE unconditionally.
REQ-020 Latency: with the request sampled at edge t, done is high in the cycle after edge t+N (N+1 cycles; 5 for WIDTH=16); issue interval is N+2 cycles minimum.
REQ-021 Operands and carry-in are captured at grant only; input changes during ADD/DONE SHALL NOT affect the result.
REQ-022 A request dropped during ADD SHALL NOT abort; the operation completes and ack still pulses.
REQ-023 A requester holding req high in the cycle after its ack is treated as a new request; the other requester, if waiting, wins per REQ-017.
REQ-024 sum, cout, and gnt_id hold their values between DONE pulses; the result register SHALL NOT be visible partially updated (sum updates only on entering DONE).
REQ-025 busy=1 in ADD and DONE, 0 in IDLE; ack0 and ack1 are never high together.
REQ-026 Overflow beyond WIDTH is reported only via cout; sum wraps modulo 2^WIDTH.

Reset
REQ-027 rst high: immediately state=IDLE, k=0, carry=0, sum=0, cout=0, done=0, ack0=ack1=0, busy=0, gnt_id=0, last-grant pointer=1.
REQ-028 Reset during ADD or DONE aborts the operation; no done/ack is issued for it; the request is re-arbitrated after rst falls if still held.
REQ-029 The first rising edge after rst deasserts acts as a normal IDLE edge.

Verification
REQ-030 req0=1, a0=0xFFFF, b0=0x0001, cin0=0 -> done/ack0 pulse 5 cycles after the sampling edge; sum=0x0000, cout=1, gnt_id=0.
REQ-031 req1=1, a1=0x0FFF, b1=0x0001, cin1=1 -> sum=0x1001, cout=0; carry propagates across slices 0-2.
REQ-032 req0 and req1 both held from reset release -> ack0 first, then ack1 at N+2 cycles later, then ack0 again; strict alternation; no ack overlap.
REQ-033 After grant to req0 (a0=0x1234, b0=0x4321), change a0 to 0xFFFF mid-ADD -> sum=0x5555, cout=0.
REQ-034 rst pulsed during slice 2 -> all outputs 0 immediately; no done; with req0 held, a new operation starts after release and completes with the correct sum.
REQ-035 req0 dropped one cycle after grant -> operation completes; ack0 pulses; FSM returns to IDLE with busy=0.
